// File: rtl/sequential_divider_if.sv
// Handshake/result bundle for the sequential divider.
// Optional build macro: DIV_DEBUG_EN adds the iteration counter 'count'.
interface sequential_divider_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
`ifdef DIV_DEBUG_EN
    logic [CW-1:0]    count;
`endif

    // Requester side: issues operands and observes results.
    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
`ifdef DIV_DEBUG_EN
        , input count
`endif
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
`ifdef DIV_DEBUG_EN
        , output count
`endif
    );
endinterface

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Shares the start/busy/done handshake of the shift-add multiplier.
// Optional build macro: DIV_DEBUG_EN exposes the iteration counter on 'count'.
module sequential_divider #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sequential_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;        // captured divisor
    logic [CW-1:0]    iter_q, iter_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] step_rem_s;
    logic [WIDTH-1:0] step_quo_s;

    // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
    always_comb begin
        shifted_s  = {rem_q, dvd_q[WIDTH-1]};
        diff_s     = shifted_s - {1'b0, dvs_q};
        step_rem_s = shifted_s[WIDTH-1:0];
        step_quo_s = {dvd_q[WIDTH-2:0], 1'b0};
        if (!diff_s[WIDTH]) begin
            step_rem_s = diff_s[WIDTH-1:0];
            step_quo_s = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
            step_rem_s = shifted_s[WIDTH-1:0];
        end
    end

    // Next-state and output decode; results only change on entry to DONE.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        iter_d      = iter_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        case (state_q)
            S_IDLE: begin
                iter_d = {CW{1'b0}};
                if (bus.start) begin
                    dvd_d = bus.dividend;
                    dvs_d = bus.divisor;
                    rem_d = {WIDTH{1'b0}};
                    if (bus.divisor != {WIDTH{1'b0}}) begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        dbz_d   = 1'b0;
                    end else begin
                        // Zero divisor: skip the iterations and report saturated quotient.
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        dbz_d       = 1'b1;
                        quotient_d  = {WIDTH{1'b1}};
                        remainder_d = bus.dividend;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                rem_d  = step_rem_s;
                dvd_d  = step_quo_s;
                iter_d = iter_q + CW'(1);
                if (iter_q == LAST_ITER) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    quotient_d  = step_quo_s;
                    remainder_d = step_rem_s;
                end else begin
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                iter_d  = {CW{1'b0}};
            end
            default: begin
                state_d = S_IDLE;
                iter_d  = {CW{1'b0}};
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= {WIDTH{1'b0}};
            dvd_q       <= {WIDTH{1'b0}};
            dvs_q       <= {WIDTH{1'b0}};
            iter_q      <= {CW{1'b0}};
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            iter_q      <= iter_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
`ifdef DIV_DEBUG_EN
    assign bus.count       = iter_q;
`endif

endmodule
